// File: rtl/seq_pipe_addsub_pkg.sv
// Shared types and helpers for the chunked, pipelined add/subtract unit.
// Operand-sized fields live in the stage module because they depend on its parameters.
package seq_pipe_addsub_pkg;

  // Per-stage control bits that travel with each transaction.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
    logic sign_a;
    logic sign_b;
  } stage_ctrl_t;

  function automatic int chunk_width(input int nbits, input int nstages);
    return (nstages > 0) ? nbits / nstages : nbits;
  endfunction

endpackage

// File: rtl/seq_pipe_addsub_stage.sv
// One pipeline stage: adds the lowest pending chunk of A and B' plus the incoming carry,
// and registers the result together with the remaining operand chunks.
module seq_pipe_addsub_stage
  import seq_pipe_addsub_pkg::*;
#(
  parameter int p_nbits   = 8,
  parameter int p_nstages = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               adv,
  input  stage_ctrl_t        prev_ctrl,
  input  logic [p_nbits-1:0] prev_ar,
  input  logic [p_nbits-1:0] prev_b,
  output stage_ctrl_t        ctrl_reg,
  output logic [p_nbits-1:0] ar_reg,
  output logic [p_nbits-1:0] b_reg
);

  localparam int cw = chunk_width(p_nbits, p_nstages);

  logic [cw:0]        chunk_sum;
  logic [p_nbits-1:0] sum_ext;
  logic [p_nbits-1:0] ar_next;
  logic [p_nbits-1:0] b_next;
  stage_ctrl_t        ctrl_next;

  // ar holds unconsumed A chunks at the bottom and finished result chunks at the top;
  // shifting right by one chunk per stage leaves the full result in place after the last one.
  always_comb begin
    chunk_sum = {1'b0, prev_ar[cw-1:0]} + {1'b0, prev_b[cw-1:0]} + {{cw{1'b0}}, prev_ctrl.carry};
    sum_ext = '0;
    sum_ext[cw-1:0] = chunk_sum[cw-1:0];
    ar_next = (prev_ar >> cw) | (sum_ext << (p_nbits - cw));
    b_next = prev_b >> cw;
    ctrl_next = prev_ctrl;
    ctrl_next.carry = chunk_sum[cw];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg <= '0;
      ar_reg   <= '0;
      b_reg    <= '0;
    end else if (adv) begin
      ctrl_reg <= ctrl_next;
      ar_reg   <= ar_next;
      b_reg    <= b_next;
    end
  end

endmodule

// File: rtl/seq_pipe_addsub_nstage.sv
// Pipelined add/subtract with val/rdy handshake; one operand chunk is resolved per stage
// and the carry is registered between stages.
module seq_pipe_addsub_nstage
  import seq_pipe_addsub_pkg::*;
#(
  parameter int p_nbits   = 8,
  parameter int p_nstages = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               sub,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out,
  output logic               cout,
  output logic               ovf
);

  localparam int last = p_nstages - 1;

  generate
    if (p_nstages < 1 || (p_nbits % p_nstages) != 0) begin : g_bad_params
      $error("seq_pipe_addsub_nstage: p_nstages must be >= 1 and divide p_nbits");
    end
  endgenerate

  stage_ctrl_t        ctrl_first;
  logic [p_nbits-1:0] b_first;
  stage_ctrl_t        prev_ctrl [p_nstages];
  stage_ctrl_t        ctrl_reg  [p_nstages];
  logic [p_nbits-1:0] prev_ar   [p_nstages];
  logic [p_nbits-1:0] prev_b    [p_nstages];
  logic [p_nbits-1:0] ar_reg    [p_nstages];
  logic [p_nbits-1:0] b_reg     [p_nstages];
  logic [p_nstages-1:0] valid_vec;
  logic [p_nstages-1:0] adv;

  // Subtraction is A + ~B + 1: invert B and inject the 1 as the stage-0 carry.
  always_comb begin
    b_first = sub ? ~in1 : in1;
    ctrl_first = '0;
    ctrl_first.valid  = in_val;
    ctrl_first.carry  = sub;
    ctrl_first.sub    = sub;
    ctrl_first.sign_a = in0[p_nbits-1];
    ctrl_first.sign_b = b_first[p_nbits-1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < p_nstages; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign prev_ctrl[gi] = ctrl_first;
        assign prev_ar[gi]   = in0;
        assign prev_b[gi]    = b_first;
      end else begin : g_body
        assign prev_ctrl[gi] = ctrl_reg[gi-1];
        assign prev_ar[gi]   = ar_reg[gi-1];
        assign prev_b[gi]    = b_reg[gi-1];
      end

      assign valid_vec[gi] = ctrl_reg[gi].valid;
      // Stage gi may move unless it and every stage after it are full while the consumer stalls.
      assign adv[gi] = out_rdy | ~(&valid_vec[last:gi]);

      seq_pipe_addsub_stage #(
        .p_nbits   (p_nbits),
        .p_nstages (p_nstages)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv[gi]),
        .prev_ctrl (prev_ctrl[gi]),
        .prev_ar   (prev_ar[gi]),
        .prev_b    (prev_b[gi]),
        .ctrl_reg  (ctrl_reg[gi]),
        .ar_reg    (ar_reg[gi]),
        .b_reg     (b_reg[gi])
      );
    end
  endgenerate

  assign in_rdy  = adv[0];
  assign out_val = ctrl_reg[last].valid;
  assign out     = ar_reg[last];
  assign cout    = ctrl_reg[last].carry;
  assign ovf     = (ctrl_reg[last].sign_a == ctrl_reg[last].sign_b) &&
                   (ar_reg[last][p_nbits-1] != ctrl_reg[last].sign_a);

endmodule

// File: tb/tb_seq_pipe_addsub_nstage.sv
// Scoreboard bench for seq_pipe_addsub_nstage: an 8-bit/2-stage and a 16-bit/4-stage instance
// checked against an arithmetic reference model.
module tb_seq_pipe_addsub_nstage;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        o;
    int          acc;
    bit          strict;
  } exp_t;

  logic clk, reset;
  logic in_val8, in_rdy8, sub8, out_val8, out_rdy8, cout8, ovf8;
  logic [7:0] a8, b8, out8;
  logic in_val16, in_rdy16, sub16, out_val16, out_rdy16, cout16, ovf16;
  logic [15:0] a16, b16, out16;

  exp_t q8[$];
  exp_t q16[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_out [2] = '{0, 0};
  bit hold_v [2] = '{0, 0};
  logic [17:0] hold_d [2];
  bit rnd8 = 0;
  bit rnd16 = 0;

  int ta [10] = '{42, 127, 255, 8, 29, 60, 13, 128, 42, 100};
  int tb [10] = '{13, 1, 1, 8, 29, 60, 42, 1, 42, 50};
  int ts [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  seq_pipe_addsub_nstage #(.p_nbits(8), .p_nstages(2)) dut8 (
    .clk(clk), .reset(reset), .in_val(in_val8), .in_rdy(in_rdy8), .in0(a8), .in1(b8),
    .sub(sub8), .out_val(out_val8), .out_rdy(out_rdy8), .out(out8), .cout(cout8), .ovf(ovf8)
  );

  seq_pipe_addsub_nstage #(.p_nbits(16), .p_nstages(4)) dut16 (
    .clk(clk), .reset(reset), .in_val(in_val16), .in_rdy(in_rdy16), .in0(a16), .in1(b16),
    .sub(sub16), .out_val(out_val16), .out_rdy(out_rdy16), .out(out16), .cout(cout16), .ovf(ovf16)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Returns {ovf, cout, result} from plain integer arithmetic on n-bit operands.
  function automatic logic [17:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                        input bit s);
    longint md, ua, ub, sa, sb, r, t;
    logic c, o;
    logic [15:0] res;
    md = longint'(1) << n;
    ua = longint'(a) & (md - 1);
    ub = longint'(b) & (md - 1);
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (s) begin
      r = ua - ub;
      c = (ua >= ub);
      t = sa - sb;
    end else begin
      r = ua + ub;
      c = (r >= md);
      t = sa + sb;
    end
    r = ((r % md) + md) % md;
    o = (t < -(md / 2)) || (t >= md / 2);
    res = 16'(r);
    return {o, c, res};
  endfunction

  task automatic push(input bit w16, input logic [15:0] a, input logic [15:0] b, input bit s,
                      input bit strict);
    exp_t e;
    logic [17:0] m;
    m = model(w16 ? 16 : 8, a, b, s);
    e.res = m[15:0];
    e.c = m[16];
    e.o = m[17];
    e.acc = cyc + 1;
    e.strict = strict;
    if (w16) q16.push_back(e);
    else q8.push_back(e);
    $display("issue dut%0d: a=%0h b=%0h sub=%0d expect res=%0h cout=%0d ovf=%0d", w16 ? 16 : 8,
             a, b, s, m[15:0], m[16], m[17]);
  endtask

  // Presents one transaction and holds it until accepted; returns at posedge+1 with in_val still high.
  task automatic send(input bit w16, input logic [15:0] a, input logic [15:0] b, input bit s,
                      input bit strict);
    bit got;
    if (w16) begin
      in_val16 = 1; a16 = a; b16 = b; sub16 = s;
    end else begin
      in_val8 = 1; a8 = a[7:0]; b8 = b[7:0]; sub8 = s;
    end
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (w16 ? in_rdy16 : in_rdy8) begin
        push(w16, a, b, s, strict);
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk(w16 ? "accept_timeout16" : "accept_timeout8", 32'(got), 1);
  endtask

  task automatic drain(input bit w16);
    for (int k = 0; k < 400; k++) begin
      if ((w16 ? q16.size() : q8.size()) == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    chk(w16 ? "drain16" : "drain8", w16 ? q16.size() : q8.size(), 0);
  endtask

  task automatic mon(input bit w16);
    logic v, r, c, o;
    logic [15:0] res;
    exp_t e;
    int lat;
    bit empty;
    v = w16 ? out_val16 : out_val8;
    r = w16 ? out_rdy16 : out_rdy8;
    res = w16 ? out16 : {8'h00, out8};
    c = w16 ? cout16 : cout8;
    o = w16 ? ovf16 : ovf8;
    lat = w16 ? 3 : 1;
    if (!reset) begin
      hold_v[w16] = 0;
    end else begin
      if (hold_v[w16]) chk(w16 ? "hold_stable16" : "hold_stable8", 32'({c, o, res}), 32'(hold_d[w16]));
      hold_v[w16] = v && !r;
      hold_d[w16] = {c, o, res};
    end
    if (v && r) begin
      n_out[w16]++;
      empty = w16 ? (q16.size() == 0) : (q8.size() == 0);
      if (empty) begin
        n_checks++;
        $display("FAIL unexpected_out%0d: got res=%0h with no transaction outstanding",
                 w16 ? 16 : 8, res);
      end else begin
        if (w16) e = q16.pop_front();
        else e = q8.pop_front();
        $display("result dut%0d: res=%0h cout=%0d ovf=%0d (expect %0h %0d %0d) latency=%0d",
                 w16 ? 16 : 8, res, c, o, e.res, e.c, e.o, cyc - e.acc);
        chk(w16 ? "res16" : "res8", 32'(res), 32'(e.res));
        chk(w16 ? "cout16" : "cout8", 32'(c), 32'(e.c));
        chk(w16 ? "ovf16" : "ovf8", 32'(o), 32'(e.o));
        if (e.strict) chk(w16 ? "latency16" : "latency8", cyc - e.acc, lat);
        else chk(w16 ? "min_latency16" : "min_latency8", 32'(cyc - e.acc >= lat), 1);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd8) out_rdy8 = 1'($urandom_range(0, 1));
      if (rnd16) out_rdy16 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int acc_n, base;
    bit took;
    reset = 0;
    in_val8 = 0; a8 = 0; b8 = 0; sub8 = 0; out_rdy8 = 1;
    in_val16 = 0; a16 = 0; b16 = 0; sub16 = 0; out_rdy16 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val8", 32'(out_val8), 0);
    chk("rst_out8", 32'(out8), 0);
    chk("rst_cout8", 32'(cout8), 0);
    chk("rst_ovf8", 32'(ovf8), 0);
    chk("rst_in_rdy8", 32'(in_rdy8), 1);
    chk("rst_out_val16", 32'(out_val16), 0);
    chk("rst_in_rdy16", 32'(in_rdy16), 1);
    @(negedge clk);
    #2 reset = 1;
    @(posedge clk);
    #1;

    // Directed back-to-back adds, carries, subtracts and mixed modes at full throughput.
    for (int i = 0; i < 10; i++) send(0, 16'(ta[i]), 16'(tb[i]), ts[i][0], 1);
    send(0, 16'h7F, 16'h7F, 1, 1);
    send(0, 16'h80, 16'h80, 0, 1);
    in_val8 = 0;
    drain(0);

    // Backpressure: exactly two accepted while the consumer stalls.
    out_rdy8 = 0;
    acc_n = 0;
    in_val8 = 1; a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); sub8 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      took = in_rdy8;
      if (took) begin
        push(0, {8'h00, a8}, {8'h00, b8}, sub8, 0);
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (took) begin
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); sub8 = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_accepted", acc_n, 2);
    @(negedge clk);
    chk("bp_in_rdy_full", 32'(in_rdy8), 0);
    @(posedge clk);
    #1;
    out_rdy8 = 1;
    @(negedge clk);
    chk("bp_in_rdy_release", 32'(in_rdy8), 1);
    if (in_rdy8) push(0, {8'h00, a8}, {8'h00, b8}, sub8, 0);
    @(posedge clk);
    #1;
    in_val8 = 0;
    drain(0);

    // Reset with two transactions in flight.
    out_rdy8 = 0;
    send(0, 16'h11, 16'h22, 0, 0);
    send(0, 16'h33, 16'h44, 1, 0);
    in_val8 = 0;
    chk("pre_reset_out_val8", 32'(out_val8), 1);
    #2 reset = 0;
    #1;
    chk("mid_reset_out_val8", 32'(out_val8), 0);
    chk("mid_reset_out8", 32'(out8), 0);
    chk("mid_reset_in_rdy8", 32'(in_rdy8), 1);
    q8.delete();
    @(negedge clk);
    #2 reset = 1;
    out_rdy8 = 1;
    base = n_out[0];
    #1;
    chk("post_reset_in_rdy8", 32'(in_rdy8), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_out8", n_out[0] - base, 0);

    // Random operands and modes with random gaps and random consumer backpressure.
    rnd8 = 1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_val8 = 0;
        @(posedge clk);
        #1;
      end
      send(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    end
    in_val8 = 0;
    rnd8 = 0;
    out_rdy8 = 1;
    drain(0);

    // Wide configuration: cross-chunk carry, signed overflow, then random traffic.
    send(1, 16'h0FFF, 16'h0001, 0, 1);
    send(1, 16'h8000, 16'h0001, 1, 1);
    send(1, 16'hFFFF, 16'hFFFF, 0, 1);
    in_val16 = 0;
    drain(1);
    rnd16 = 1;
    for (int i = 0; i < 20; i++)
      send(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0);
    in_val16 = 0;
    rnd16 = 0;
    out_rdy16 = 1;
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
